scan_shift_ctrl: RTL and testbench
==================================

SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 SHALL have parameter CHAINS, default 5, number of scan chains driven and sampled.
REQ-002 SHALL have parameter LEN_W, default 10, width of chain-length and pattern-count fields.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan session.
REQ-006 SHALL have port chain_len  input  LEN_W  shift cycles per pattern (L), sampled on accepted start.
REQ-007 SHALL have port pat_count  input  LEN_W  number of patterns (P), sampled on accepted start.
REQ-008 SHALL have port pat_valid  input  1  pattern source has a slice available.
REQ-009 SHALL have port pat_data  input  CHAINS  one bit per chain for the current shift slice.
REQ-010 SHALL have port pat_ready  output  1  controller consumes pat_data this cycle.
REQ-011 SHALL have ports scan_in0..scan_in4  output  1 each  serial data into chains 0..4.
REQ-012 SHALL have ports scan_out0..scan_out4  input  1 each  serial data from chains 0..4.
REQ-013 SHALL have ports scan_enable, test_mode  output  1 each  shift-enable and test-mode to the DUT.
REQ-014 SHALL have port rsp_valid  output  1  rsp_data holds one sampled slice; no backpressure.
REQ-015 SHALL have port rsp_data  output  CHAINS  bit N = scan_outN sampled on a shift edge.
REQ-016 SHALL have port rsp_last  output  1  marks the final response slice of the session.
REQ-017 SHALL have ports busy, done, err  output  1 each  session active, one-cycle completion pulse, sticky underrun flag.

Function
REQ-018 SHALL implement states IDLE, SHIFT, CAPTURE, UNLOAD, FINISH.
REQ-019 IDLE: start accepted only when chain_len!=0 and pat_count!=0; otherwise ignored, no state change.
REQ-020 Accepted start SHALL latch L and P, clear err, set busy and test_mode next cycle, enter SHIFT with shift counter=0 and pattern counter=0.
REQ-021 start while busy SHALL be ignored.
REQ-022 SHIFT: pat_ready=1 combinationally. Each cycle with pat_valid=1: scan_inN<=pat_data[N], scan_enable<=1, shift counter increments.
REQ-023 SHIFT SHALL last exactly L accepted cycles, then enter CAPTURE.
REQ-024 CAPTURE SHALL be exactly one cycle. scan_enable registered 0, so exactly one DUT capture edge has scan_enable=0. Pattern counter then increments; go to SHIFT if counter<P, else UNLOAD.
REQ-025 UNLOAD: pat_ready=0, scan_inN<=0, scan_enable<=1 for exactly L cycles, then FINISH.
REQ-026 FINISH: scan_enable<=0, test_mode<=0, busy<=0, done=1 for one cycle, then IDLE.
REQ-027 Response sampling: on every rising edge where registered scan_enable==1, rsp_data[N]<=scan_outN and rsp_valid<=1; otherwise rsp_valid<=0.
REQ-028 Response count per session SHALL be exactly (P+1)*L; the first L slices are pre-session chain contents.
REQ-029 Latency from pattern slice acceptance to its shift-out slice SHALL be 2 cycles; a pattern's captured response emerges in the next SHIFT or UNLOAD.
REQ-030 rsp_last SHALL be 1 only with the (P+1)*L-th rsp_valid.
REQ-031 Underrun: pat_valid=0 while in SHIFT SHALL abort the session within the same cycle's edge. Effects: err<=1, scan_enable<=0, test_mode<=0, busy<=0, no done pulse, next state IDLE.
REQ-032 Counters SHALL be LEN_W bits with no wrap; L=2^LEN_W-1 and P=2^LEN_W-1 SHALL be supported.

Reset
REQ-033 reset SHALL force IDLE. All outputs 0: scan_in0..4, scan_enable, test_mode, pat_ready, rsp_valid, rsp_data, rsp_last, busy, done, err.
REQ-034 reset asserted mid-session SHALL abort with no done pulse; it overrides start in the same cycle.

Verification
REQ-035 L=4, P=1, pat_data=5'h1F for 4 slices, DUT chains preloaded 0 -> 8 rsp_valid. First 4 rsp_data=0. Exactly one scan_enable=0 edge between shifts. rsp_last on the 8th slice. done pulse 1 cycle after FINISH entry.
REQ-036 L=3, P=2, pat_valid held 1 -> state sequence SHIFT(3) CAPTURE SHIFT(3) CAPTURE UNLOAD(3) FINISH. 9 responses.
REQ-037 pat_valid dropped on the 2nd SHIFT cycle -> err=1, busy=0, scan_enable=0, test_mode=0 next cycle. No done. err cleared by the next accepted start.
REQ-038 start with chain_len=0, then pat_count=0, then start while busy -> all ignored; busy unchanged.
REQ-039 reset asserted during UNLOAD -> all outputs 0 next cycle, no done. A subsequent start runs a full session normally.
REQ-040 Loopback (scan_outN tied to a 4-flop chain fed by scan_inN), L=4, P=1, pattern 5'h15 -> slices 5..8 of rsp_data equal the shifted-in pattern.

Source files
------------

// File: rtl/scan_shift_ctrl.sv
// rtl/scan_shift_ctrl.sv - scan chain shift/capture/unload sequencer with response sampling
// The five chain pins are fixed ports, so CHAINS is expected to be at least 5.
module scan_shift_ctrl #(
   parameter int CHAINS = 5,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  chain_len,
   input  logic [LEN_W-1:0]  pat_count,
   input  logic              pat_valid,
   input  logic [CHAINS-1:0] pat_data,
   output logic              pat_ready,
   output logic              scan_in0,
   output logic              scan_in1,
   output logic              scan_in2,
   output logic              scan_in3,
   output logic              scan_in4,
   input  logic              scan_out0,
   input  logic              scan_out1,
   input  logic              scan_out2,
   input  logic              scan_out3,
   input  logic              scan_out4,
   output logic              scan_enable,
   output logic              test_mode,
   output logic              rsp_valid,
   output logic [CHAINS-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  pat_q;
   logic [LEN_W-1:0]  shift_cnt_q;
   logic [LEN_W-1:0]  pat_cnt_q;
   logic [LEN_W-1:0]  pat_cnt_d;
   logic              shift_last_d;
   logic [CHAINS-1:0] scan_in_q;
   logic [CHAINS-1:0] scan_out_v;
   logic              se_q;
   logic              tm_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              rsp_valid_q;
   logic              rsp_last_q;
   logic [CHAINS-1:0] rsp_data_q;

   always_comb begin
      scan_out_v    = '0;
      scan_out_v[0] = scan_out0;
      scan_out_v[1] = scan_out1;
      scan_out_v[2] = scan_out2;
      scan_out_v[3] = scan_out3;
      scan_out_v[4] = scan_out4;
   end

   // Counters never exceed L-1 / P, so the LEN_W-bit arithmetic cannot wrap.
   assign pat_cnt_d    = pat_cnt_q + 1'b1;
   assign shift_last_d = (shift_cnt_q == len_q - 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         pat_q       <= '0;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
         scan_in_q   <= '0;
         se_q        <= 1'b0;
         tm_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         done_q      <= 1'b0;
         rsp_valid_q <= se_q;
         rsp_last_q  <= se_q && (state_q == FINISH);
         if (se_q) begin
            rsp_data_q <= scan_out_v;
         end
         case (state_q)
            IDLE: begin
               if (start && (chain_len != '0) && (pat_count != '0)) begin
                  len_q       <= chain_len;
                  pat_q       <= pat_count;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
                  tm_q        <= 1'b1;
                  shift_cnt_q <= '0;
                  pat_cnt_q   <= '0;
                  state_q     <= SHIFT;
               end
            end
            SHIFT: begin
               if (pat_valid) begin
                  scan_in_q <= pat_data;
                  se_q      <= 1'b1;
                  if (shift_last_d) begin
                     shift_cnt_q <= '0;
                     state_q     <= CAPTURE;
                  end else begin
                     shift_cnt_q <= shift_cnt_q + 1'b1;
                  end
               end else begin
                  // Source starved mid-pattern: abandon the session without a done pulse.
                  err_q   <= 1'b1;
                  se_q    <= 1'b0;
                  tm_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CAPTURE: begin
               se_q      <= 1'b0;
               pat_cnt_q <= pat_cnt_d;
               state_q   <= (pat_cnt_d < pat_q) ? SHIFT : UNLOAD;
            end
            UNLOAD: begin
               scan_in_q <= '0;
               se_q      <= 1'b1;
               if (shift_last_d) begin
                  shift_cnt_q <= '0;
                  state_q     <= FINISH;
               end else begin
                  shift_cnt_q <= shift_cnt_q + 1'b1;
               end
            end
            FINISH: begin
               se_q    <= 1'b0;
               tm_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pat_ready   = (state_q == SHIFT);
   assign scan_in0    = scan_in_q[0];
   assign scan_in1    = scan_in_q[1];
   assign scan_in2    = scan_in_q[2];
   assign scan_in3    = scan_in_q[3];
   assign scan_in4    = scan_in_q[4];
   assign scan_enable = se_q;
   assign test_mode   = tm_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_last    = rsp_last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// tb/tb_scan_shift_ctrl.sv - directed bench for scan_shift_ctrl with a 4-flop loopback chain model
module tb_scan_shift_ctrl;
   localparam int CH = 5;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [LW-1:0] chain_len;
   logic [LW-1:0] pat_count;
   logic          pat_valid;
   logic [CH-1:0] pat_data;
   logic          pat_ready;
   logic          scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
   logic          scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
   logic          scan_enable, test_mode, rsp_valid, rsp_last, busy, done, err;
   logic [CH-1:0] rsp_data;

   always #5 clk = ~clk;

   scan_shift_ctrl #(.CHAINS(CH), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .chain_len(chain_len), .pat_count(pat_count),
      .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
      .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2), .scan_in3(scan_in3), .scan_in4(scan_in4),
      .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2), .scan_out3(scan_out3), .scan_out4(scan_out4),
      .scan_enable(scan_enable), .test_mode(test_mode), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .busy(busy), .done(done), .err(err)
   );

   // Chain model: shifts while scan_enable is high, holds on capture edges.
   logic          model_clr;
   logic [3:0]    ch [CH];
   logic [CH-1:0] sin_v;
   assign sin_v = {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
   always @(posedge clk) begin
      for (int n = 0; n < CH; n++) begin
         if (model_clr) ch[n] <= 4'h0;
         else if (scan_enable) ch[n] <= {ch[n][2:0], sin_v[n]};
      end
   end
   assign scan_out0 = ch[0][3];
   assign scan_out1 = ch[1][3];
   assign scan_out2 = ch[2][3];
   assign scan_out3 = ch[3][3];
   assign scan_out4 = ch[4][3];

   int total = 0;
   int bad = 0;
   int rsp_cnt, last_cnt, last_idx, done_cnt, gap_cnt;
   logic seen_se;
   logic [CH-1:0] rsp_log [0:2047];
   logic [15:0] se_hist, rdy_hist, busy_hist, done_hist;

   task automatic clear_mon();
      rsp_cnt = 0; last_cnt = 0; last_idx = 0; done_cnt = 0; gap_cnt = 0; seen_se = 1'b0;
      se_hist = '0; rdy_hist = '0; busy_hist = '0; done_hist = '0;
   endtask

   task automatic step();
      @(negedge clk);
      if (rsp_valid) begin
         if (rsp_cnt < 2048) rsp_log[rsp_cnt] = rsp_data;
         rsp_cnt++;
         if (rsp_last) begin
            last_cnt++;
            last_idx = rsp_cnt;
         end
      end
      if (done) done_cnt++;
      if (test_mode && !scan_enable && seen_se) gap_cnt++;
      if (scan_enable) seen_se = 1'b1;
      se_hist   = {se_hist[14:0], scan_enable};
      rdy_hist  = {rdy_hist[14:0], pat_ready};
      busy_hist = {busy_hist[14:0], busy};
      done_hist = {done_hist[14:0], done};
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_session(input int l, input int p, input logic [CH-1:0] d, input int budget);
      chain_len = l[LW-1:0]; pat_count = p[LW-1:0]; pat_data = d; pat_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      clear_mon();
      for (int i = 0; i < budget && done_cnt == 0; i++) step();
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL session_timeout: L=%0d P=%0d no done within %0d cycles", l, p, budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; model_clr = 1'b1; start = 1'b0; pat_valid = 1'b0;
      chain_len = '0; pat_count = '0; pat_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {17'd0, sin_v, scan_enable, test_mode, pat_ready, rsp_valid, rsp_data, rsp_last}, 32'd0);
      chk("reset_status", {29'd0, busy, done, err}, 32'd0);
      reset = 1'b0; model_clr = 1'b0;
   endtask

   task automatic test_basic(input logic [CH-1:0] pat, input string tag);
      model_clr = 1'b1; step(); model_clr = 1'b0;
      run_session(4, 1, pat, 40);
      chk({tag, "_rsp_count"}, rsp_cnt, 8);
      for (int i = 0; i < 4; i++) chk({tag, "_pre_slice"}, rsp_log[i], 0);
      for (int i = 4; i < 8; i++) chk({tag, "_pat_slice"}, rsp_log[i], pat);
      chk({tag, "_last_idx"}, last_idx, 8);
      chk({tag, "_last_cnt"}, last_cnt, 1);
      chk({tag, "_capture_gaps"}, gap_cnt, 1);
      step();
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_idle_after"}, {busy, test_mode, scan_enable, err}, 0);
   endtask

   task automatic test_sequence();
      chain_len = 3; pat_count = 2; pat_data = 5'h0C; pat_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      clear_mon();
      repeat (13) step();
      chk("seq_scan_enable", se_hist[12:0], 13'b0111011101110);
      chk("seq_pat_ready", rdy_hist[12:0], 13'b1110111000000);
      chk("seq_busy", busy_hist[12:0], 13'b1111111111110);
      chk("seq_done", done_hist[12:0], 13'b0000000000001);
      chk("seq_rsp_count", rsp_cnt, 9);
      chk("seq_last_idx", last_idx, 9);
   endtask

   task automatic test_underrun();
      chain_len = 4; pat_count = 1; pat_data = 5'h0A; pat_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      clear_mon();
      step();
      pat_valid = 1'b0;
      step();
      chk("underrun_flags", {err, busy, scan_enable, test_mode, pat_ready}, 5'b10000);
      pat_valid = 1'b1;
      repeat (10) step();
      chk("underrun_no_done", done_cnt, 0);
      chk("underrun_err_sticky", {err, busy}, 2'b10);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("underrun_err_cleared", {err, busy}, 2'b01);
      for (int i = 0; i < 40 && done_cnt == 0; i++) step();
      chk("underrun_restart_done", done_cnt, 1);
   endtask

   task automatic test_ignored();
      chain_len = 0; pat_count = 3; pat_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_len0", {busy, test_mode}, 0);
      chain_len = 3; pat_count = 0; start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_pat0", {busy, test_mode}, 0);
      chain_len = 2; pat_count = 1; start = 1'b1;
      step();
      start = 1'b0;
      clear_mon();
      step();
      chain_len = 7; pat_count = 7; start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_busy_start", busy, 1);
      for (int i = 0; i < 40 && done_cnt == 0; i++) step();
      chk("ign_rsp_count", rsp_cnt, 4);
      chk("ign_done", done_cnt, 1);
   endtask

   task automatic test_reset_unload();
      chain_len = 4; pat_count = 1; pat_data = 5'h1F; pat_valid = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      clear_mon();
      repeat (6) step();
      chk("unload_reached", {scan_enable, pat_ready, busy}, 3'b101);
      reset = 1'b1; model_clr = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; model_clr = 1'b0; start = 1'b0;
      chk("rst_unload_outputs", {14'd0, sin_v, scan_enable, test_mode, pat_ready, rsp_valid, rsp_data, rsp_last, busy, done, err}, 32'd0);
      repeat (5) step();
      chk("rst_unload_no_done", {done_cnt[30:0], busy}, 0);
      run_session(4, 1, 5'h15, 40);
      chk("rst_resume_rsp", rsp_cnt, 8);
      chk("rst_resume_last", last_idx, 8);
   endtask

   task automatic test_boundaries();
      run_session(1023, 1, 5'h11, 2200);
      chk("max_len_rsp", rsp_cnt, 2046);
      chk("max_len_last", last_idx, 2046);
      run_session(1, 1023, 5'h03, 2200);
      chk("max_pat_rsp", rsp_cnt, 1024);
      chk("max_pat_last", last_idx, 1024);
      chk("max_pat_gaps", gap_cnt, 1023);
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic(5'h1F, "basic");
      test_sequence();
      test_underrun();
      test_ignored();
      test_reset_unload();
      test_basic(5'h15, "loopback");
      test_boundaries();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
